corr_scan_ctrl: RTL and testbench
=================================

CORR_SCAN_CTRL -- requirements
Module: corr_scan_ctrl

Interface
REQ-001 SHALL have parameter REGDEPTH, default 52: number of taps in the sample window driven by this controller.
REQ-002 SHALL have parameter TAP_W, default 6: tap index width, with 2^TAP_W >= REGDEPTH.
REQ-003 SHALL have parameter CNT_W, default 16: result counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1: synchronous abort and window clear.
REQ-007 SHALL have port in_valid, input, 1: upstream sample available.
REQ-008 SHALL have port in_ready, output, 1: controller can accept a sample.
REQ-009 SHALL have port shift_en, output, 1: one-cycle shift strobe to the window register.
REQ-010 SHALL have port tap_sel, output, TAP_W: window tap index presented to the MAC datapath.
REQ-011 SHALL have port mac_clr, output, 1: accumulator clear, coincident with the first tap.
REQ-012 SHALL have port mac_en, output, 1: accumulate the selected tap this cycle.
REQ-013 SHALL have port out_valid, output, 1: accumulator result ready.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port win_full, output, 1: REGDEPTH samples shifted since the last reset or flush.
REQ-016 SHALL have port res_cnt, output, CNT_W: count of results handed off.

Function
REQ-017 SHALL implement states IDLE, SCAN and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; in SCAN and DONE, in_ready SHALL be 0.
REQ-019 Accept SHALL mean in_valid & in_ready & ~flush; shift_en SHALL be combinationally equal to accept, so the window register latches din on the same edge.
REQ-020 fill_cnt SHALL increment on each accept and saturate at REGDEPTH; win_full SHALL be (fill_cnt == REGDEPTH).
REQ-021 On accept, if the incremented fill_cnt equals REGDEPTH, state SHALL go to SCAN; otherwise state SHALL stay IDLE.
REQ-022 In SCAN, mac_en SHALL be 1 and tap_sel SHALL step 0,1,...,REGDEPTH-1 on consecutive cycles.
REQ-023 mac_clr SHALL be 1 only in the SCAN cycle with tap_sel == 0.
REQ-024 After the cycle with tap_sel == REGDEPTH-1, state SHALL go to DONE and tap_sel SHALL return to 0.
REQ-025 Timing SHALL be: accept in cycle C0, SCAN in C1..C(REGDEPTH), out_valid first high in C(REGDEPTH+1).
REQ-026 In DONE, out_valid SHALL hold at 1 until out_ready is 1 (unbounded backpressure).
REQ-027 On that handshake, the next state SHALL be IDLE and res_cnt SHALL increment, wrapping modulo 2^CNT_W.
REQ-028 Outside SCAN, mac_en, mac_clr and tap_sel SHALL be 0; outside DONE, out_valid SHALL be 0.
REQ-029 flush SHALL force the next state to IDLE, fill_cnt 0 and tap_sel 0 from any state.
REQ-030 flush SHALL drop any pending result without incrementing res_cnt.
REQ-031 flush SHALL take priority over accept and over the out handshake in the same cycle.
REQ-032 A flush asserted during SCAN SHALL suppress mac_en from the following cycle onward.
REQ-033 in_valid held high in DONE SHALL NOT shift; the sample SHALL be accepted in the first IDLE cycle after the handshake.
REQ-034 Once win_full, every accept SHALL start a full scan (one result per sample).
REQ-035 REGDEPTH == 1 SHALL be legal: SCAN lasts one cycle, with mac_clr and mac_en together.

Reset
REQ-036 On rst low, the block SHALL asynchronously enter IDLE with fill_cnt 0, tap_sel 0, res_cnt 0, and mac_en, mac_clr, out_valid, win_full and shift_en all 0.
REQ-037 in_ready SHALL be 0 while rst is low and 1 from the first cycle after release.
REQ-038 Reset asserted mid-SCAN or in DONE SHALL discard the scan with no output pulse.

Verification
REQ-039 SHALL cover: 51 accepts with in_valid constant 1 -> 51 shift_en pulses, win_full 0, no mac_en, res_cnt 0.
REQ-040 SHALL cover: 52nd accept -> win_full 1, tap_sel 0..51 over 52 cycles, mac_clr only with tap 0, out_valid in cycle C53, res_cnt 1 after out_ready.
REQ-041 SHALL cover: out_ready held 0 for 20 cycles in DONE with in_valid 1 -> out_valid stable, no shift_en, one accept after the handshake.
REQ-042 SHALL cover: flush at tap_sel 30 -> mac_en 0 next cycle, out_valid never rises, win_full 0, res_cnt unchanged.
REQ-043 SHALL cover: flush and in_valid high in the same IDLE cycle -> no shift_en, fill_cnt 0.
REQ-044 SHALL cover: rst low in DONE, then released -> out_valid 0 immediately, in_ready 1 next cycle, res_cnt 0.

Source files
------------

// File: rtl/corr_scan_ctrl.sv
// Sequencing controller for a tapped correlator window: fills the window,
// walks every tap through the MAC once per new sample, then hands the result off.
module corr_scan_ctrl #(
    parameter int REGDEPTH = 52,
    parameter int TAP_W    = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic [TAP_W-1:0] tap_sel,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             win_full,
    output logic [CNT_W-1:0] res_cnt,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and flush cancels any transfer.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // One spare bit so a window depth of exactly 2^TAP_W still fits the fill count.
    localparam logic [TAP_W:0]   FILL_MAX = (TAP_W + 1)'(REGDEPTH);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(REGDEPTH - 1);

    logic [1:0]       state_q, state_d;
    logic [TAP_W:0]   fill_q, fill_d, fill_inc;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic             accept;

    assign in_ready = rst && (state_q == IDLE);
    assign accept   = in_valid && in_ready && !flush;
    assign fill_inc = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        tap_d   = tap_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
            fill_d  = '0;
            tap_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        fill_d = fill_inc;
                        // Once the window is full every new sample triggers a rescan.
                        if (fill_inc == FILL_MAX) state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (tap_q == TAP_LAST) begin
                        state_d = DONE;
                        tap_d   = '0;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        res_d   = res_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fill_q  <= '0;
            tap_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            tap_q   <= tap_d;
            res_q   <= res_d;
        end
    end

    assign shift_en  = accept;
    assign mac_en    = (state_q == SCAN);
    assign mac_clr   = mac_en && (tap_q == '0);
    assign tap_sel   = mac_en ? tap_q : '0;
    assign out_valid = (state_q == DONE);
    assign win_full  = (fill_q == FILL_MAX);
    assign res_cnt   = res_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_corr_scan_ctrl.sv
// Scenario bench for corr_scan_ctrl: default 52-tap instance plus a 1-tap
// instance with a narrow result counter to exercise wrap-around.
module tb_corr_scan_ctrl;

    localparam int CW = 16;

    logic          clk, rst;
    logic          flush, in_valid, out_ready;
    logic          in_ready, shift_en, mac_clr, mac_en, out_valid, win_full;
    logic [5:0]    tap_sel;
    logic [CW-1:0] res_cnt;
    logic [1:0]    dbg_state;

    logic          flush_1, in_valid_1, out_ready_1;
    logic          in_ready_1, shift_en_1, mac_clr_1, mac_en_1, out_valid_1, win_full_1;
    logic [0:0]    tap_sel_1;
    logic [3:0]    res_cnt_1;
    logic [1:0]    dbg_state_1;

    int            n_vec = 0;
    int            n_err = 0;
    int            m_res = 0;
    logic [CW-1:0] exp_q[$];
    logic [3:0]    exp1_q[$];

    corr_scan_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .shift_en(shift_en), .tap_sel(tap_sel), .mac_clr(mac_clr), .mac_en(mac_en),
        .out_valid(out_valid), .out_ready(out_ready), .win_full(win_full),
        .res_cnt(res_cnt), .dbg_state(dbg_state)
    );

    corr_scan_ctrl #(.REGDEPTH(1), .TAP_W(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .shift_en(shift_en_1), .tap_sel(tap_sel_1), .mac_clr(mac_clr_1), .mac_en(mac_en_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .win_full(win_full_1),
        .res_cnt(res_cnt_1), .dbg_state(dbg_state_1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // driver: apply inputs just after the falling edge, settle, then sample
    task automatic next(input logic iv, input logic fl, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        flush     = fl;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        flush_1 = 1'b0; in_valid_1 = 1'b0; out_ready_1 = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, shift_en, mac_en, mac_clr, out_valid, win_full} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {in_ready, shift_en, mac_en, mac_clr, out_valid, win_full});
        end
        n_vec++;
        if (tap_sel !== 6'd0 || res_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_regs: got tap %0d cnt %0d expected 0 0", tap_sel, res_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_release: got ready %b state %0d expected 1 0", in_ready, dbg_state);
        end
    endtask

    task automatic test_fill();
        int shifts = 0;
        int bad = 0;
        for (int i = 0; i < 51; i++) begin
            next(1'b1, 1'b0, 1'b0);
            if (shift_en === 1'b1) shifts++;
            if (mac_en !== 1'b0 || win_full !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        next(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (shifts !== 51) begin
            n_err++;
            $display("FAIL fill_shifts: got %0d expected 51", shifts);
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL fill_side_effects: got %0d bad cycles expected 0", bad);
        end
        n_vec++;
        if (win_full !== 1'b0 || res_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL fill_end: got full %b cnt %0d expected 0 0", win_full, res_cnt);
        end
    endtask

    task automatic test_scan();
        int bad = 0;
        logic [CW-1:0] want;
        next(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (shift_en !== 1'b1) begin
            n_err++;
            $display("FAIL scan_accept: got shift %b expected 1", shift_en);
        end
        exp_q.push_back(CW'(m_res + 1));
        for (int k = 0; k < 52; k++) begin
            next(1'b0, 1'b0, 1'b0);
            if (mac_en !== 1'b1 || tap_sel !== 6'(k) || mac_clr !== (k == 0) ||
                out_valid !== 1'b0 || in_ready !== 1'b0 || win_full !== 1'b1) begin
                bad++;
                if (bad == 1)
                    $display("FAIL scan_step: got tap %0d en %b clr %b expected tap %0d en 1 clr %b",
                             tap_sel, mac_en, mac_clr, k, (k == 0));
            end
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL scan_sequence: got %0d bad cycles expected 0", bad);
        end
        next(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1 || mac_en !== 1'b0 || tap_sel !== 6'd0) begin
            n_err++;
            $display("FAIL scan_done_c53: got valid %b en %b tap %0d expected 1 0 0",
                     out_valid, mac_en, tap_sel);
        end
        next(1'b0, 1'b0, 1'b0);
        want = exp_q.pop_front();
        m_res++;
        n_vec++;
        if (res_cnt !== want || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL scan_handoff: got cnt %0d valid %b ready %b expected %0d 0 1",
                     res_cnt, out_valid, in_ready, want);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        logic [CW-1:0] want;
        next(1'b1, 1'b0, 1'b0);
        exp_q.push_back(CW'(m_res + 1));
        for (int k = 0; k < 52; k++) begin
            next(1'b1, 1'b0, 1'b0);
            if (shift_en !== 1'b0 || mac_en !== 1'b1) bad++;
        end
        for (int k = 0; k < 20; k++) begin
            next(1'b1, 1'b0, 1'b0);
            if (out_valid !== 1'b1 || shift_en !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
        end
        next(1'b1, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1 || shift_en !== 1'b0) begin
            n_err++;
            $display("FAIL bp_handshake: got valid %b shift %b expected 1 0", out_valid, shift_en);
        end
        next(1'b1, 1'b0, 1'b0);
        want = exp_q.pop_front();
        m_res++;
        n_vec++;
        if (shift_en !== 1'b1 || res_cnt !== want) begin
            n_err++;
            $display("FAIL bp_reaccept: got shift %b cnt %0d expected 1 %0d", shift_en, res_cnt, want);
        end
        exp_q.push_back(CW'(m_res + 1));
        next(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (shift_en !== 1'b0 || mac_en !== 1'b1 || mac_clr !== 1'b1) begin
            n_err++;
            $display("FAIL bp_single_accept: got shift %b en %b clr %b expected 0 1 1",
                     shift_en, mac_en, mac_clr);
        end
    endtask

    task automatic test_flush_scan();
        int bad = 0;
        bit found = 1'b0;
        for (int g = 0; g < 60 && !found; g++) begin
            next(1'b0, 1'b0, 1'b0);
            if (tap_sel === 6'd30) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL flush_find_tap30: got timeout expected tap 30");
        end
        flush = 1'b1;
        #1;
        next(1'b0, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        n_vec++;
        if (mac_en !== 1'b0 || in_ready !== 1'b1 || win_full !== 1'b0 || tap_sel !== 6'd0) begin
            n_err++;
            $display("FAIL flush_scan_after: got en %b ready %b full %b tap %0d expected 0 1 0 0",
                     mac_en, in_ready, win_full, tap_sel);
        end
        for (int k = 0; k < 60; k++) begin
            next(1'b0, 1'b0, 1'b1);
            if (out_valid !== 1'b0 || mac_en !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0 || res_cnt !== CW'(m_res)) begin
            n_err++;
            $display("FAIL flush_no_result: got %0d bad cycles cnt %0d expected 0 %0d", bad, res_cnt, m_res);
        end
    endtask

    task automatic test_flush_idle();
        int bad = 0;
        for (int i = 0; i < 10; i++) next(1'b1, 1'b0, 1'b0);
        next(1'b1, 1'b1, 1'b0);
        n_vec++;
        if (shift_en !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle_shift: got %b expected 0", shift_en);
        end
        for (int i = 0; i < 51; i++) begin
            next(1'b1, 1'b0, 1'b0);
            if (shift_en !== 1'b1 || win_full !== 1'b0 || mac_en !== 1'b0) bad++;
        end
        next(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (bad !== 0 || shift_en !== 1'b1 || win_full !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle_refill: got %0d bad cycles shift %b full %b expected 0 1 0",
                     bad, shift_en, win_full);
        end
        exp_q.push_back(CW'(m_res + 1));
    endtask

    task automatic test_reset_done();
        for (int k = 0; k < 52; k++) next(1'b0, 1'b0, 1'b0);
        next(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstdone_reach_done: got valid %b expected 1", out_valid);
        end
        rst = 1'b0;
        #1;
        exp_q.delete();
        m_res = 0;
        n_vec++;
        if ({out_valid, in_ready, mac_en, win_full} !== 4'b0 || res_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rstdone_async: got %b cnt %0d expected 0000 0",
                     {out_valid, in_ready, mac_en, win_full}, res_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        next(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rstdone_release: got ready %b valid %b cnt %0d expected 1 0 0",
                     in_ready, out_valid, res_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        logic [CW-1:0] want;
        for (int i = 0; i < 51; i++) next(1'b1, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            next(1'b1, 1'b0, 1'b1);
            if (r > 0) begin
                want = exp_q.pop_front();
                m_res++;
                n_vec++;
                if (res_cnt !== want) begin
                    n_err++;
                    $display("FAIL b2b_cnt: got %0d expected %0d", res_cnt, want);
                end
            end
            if (shift_en !== 1'b1) bad++;
            exp_q.push_back(CW'(m_res + 1));
            for (int k = 0; k < 52; k++) begin
                next(1'b1, 1'b0, 1'b1);
                if (mac_en !== 1'b1 || shift_en !== 1'b0) bad++;
            end
            next(1'b1, 1'b0, 1'b1);
            if (out_valid !== 1'b1) bad++;
        end
        next(1'b0, 1'b0, 1'b0);
        want = exp_q.pop_front();
        m_res++;
        n_vec++;
        if (res_cnt !== want || bad !== 0) begin
            n_err++;
            $display("FAIL b2b_final: got cnt %0d bad %0d expected %0d 0", res_cnt, bad, want);
        end
    endtask

    task automatic test_depth1();
        int bad = 0;
        int r1 = 0;
        logic [3:0] want;
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            in_valid_1 = 1'b1;
            out_ready_1 = 1'b1;
            #1;
            if (r > 0) begin
                want = exp1_q.pop_front();
                r1++;
                if (res_cnt_1 !== want) bad++;
            end
            if (shift_en_1 !== 1'b1) bad++;
            exp1_q.push_back(4'(r1 + 1));
            @(negedge clk);
            #1;
            if (mac_en_1 !== 1'b1 || mac_clr_1 !== 1'b1 || tap_sel_1 !== 1'b0 ||
                out_valid_1 !== 1'b0 || win_full_1 !== 1'b1) bad++;
            @(negedge clk);
            #1;
            if (out_valid_1 !== 1'b1 || mac_en_1 !== 1'b0 || shift_en_1 !== 1'b0) bad++;
        end
        @(negedge clk);
        in_valid_1 = 1'b0;
        #1;
        want = exp1_q.pop_front();
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL depth1_sequence: got %0d bad cycles expected 0", bad);
        end
        n_vec++;
        if (res_cnt_1 !== want) begin
            n_err++;
            $display("FAIL depth1_wrap: got %0d expected %0d", res_cnt_1, want);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_scan();
        test_backpressure();
        test_flush_scan();
        test_flush_idle();
        test_reset_done();
        test_back_to_back();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
